display_scan: RTL and testbench

Output stage of the watch, directly downstream of `control`. It takes the packed `time_data` word plus `am_pm_div` and `alerm_equal`, and drives a six-digit multiplexed seven-segment display (HH MM SS) and a gated alarm buzzer. Each scan frame is snapshotted atomically, so a digit never tears mid-frame.

---
 rtl/display_scan.sv | 141 ++++++++++++++
 tb/tb_display_scan.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Six-digit multiplexed seven-segment scanner with frame snapshot and gated alarm buzzer.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int BEEP_DIV = 25000,
    parameter int GATE_DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] time_data,
    input  logic        am_pm_div,
    input  logic        alerm_equal,
    output logic [7:0]  seg,
    output logic [5:0]  digit_sel,
    output logic        buzzer
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam int GW = (GATE_DIV > 1) ? $clog2(GATE_DIV) : 1;
    localparam logic [SW-1:0] SLAST = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(BEEP_DIV - 1);
    localparam logic [GW-1:0] GLAST = GW'(GATE_DIV - 1);

    function automatic logic [7:0] seven(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic          active;
    logic [18:0]   snap;

    logic [2:0]    next_idx;
    logic          frame_start;
    logic [18:0]   src;
    logic [5:0]    fld;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic [7:0]    next_seg;

    // Digit 0 decodes straight from the inputs so the snapshot and its first digit agree.
    always_comb begin
        next_idx    = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        frame_start = (next_idx == 3'd0);
        src         = frame_start ? {time_data, am_pm_div} : snap;
        case (next_idx)
            3'd0, 3'd1: fld = src[18:13];
            3'd2, 3'd3: fld = src[12:7];
            default:    fld = src[6:1];
        endcase
        tens  = 4'(fld / 6'd10);
        units = 4'(fld % 6'd10);
        if (fld > 6'd59) begin
            next_seg = 8'hBF;
        end else begin
            next_seg = seven(next_idx[0] ? units : tens);
`ifdef LEADING_ZERO_BLANK_EN
            if (next_idx == 3'd0 && tens == 4'd0) next_seg = 8'hFF;
`endif
        end
        if (next_idx == 3'd5 && src[0]) next_seg[7] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_cnt  <= '0;
            idx       <= 3'd5;
            active    <= 1'b0;
            snap      <= '0;
            seg       <= 8'hFF;
            digit_sel <= 6'h3F;
        end else if (!active || scan_cnt == SLAST) begin
            scan_cnt  <= '0;
            idx       <= next_idx;
            active    <= 1'b1;
            seg       <= next_seg;
            digit_sel <= ~(6'b1 << next_idx);
            if (frame_start) snap <= src;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [BW-1:0] tone_cnt, tone_cnt_n;
    logic [GW-1:0] gate_cnt, gate_cnt_n;
    logic          tone, tone_n;
    logic          gate, gate_n;
    logic          alarm_d;

    always_comb begin
        tone_cnt_n = tone_cnt + 1'b1;
        gate_cnt_n = gate_cnt;
        tone_n     = tone;
        gate_n     = gate;
        if (tone_cnt == BLAST) begin
            tone_cnt_n = '0;
            tone_n     = ~tone;
            if (gate_cnt == GLAST) begin
                gate_cnt_n = '0;
                gate_n     = ~gate;
            end else begin
                gate_cnt_n = gate_cnt + 1'b1;
            end
        end
    end

    // The first edge of an alarm only arms the generator; counting starts after it.
    always_ff @(posedge clock) begin
        if (!reset) alarm_d <= 1'b0;
        else        alarm_d <= alerm_equal;
        if (!reset || !alerm_equal || !alarm_d) begin
            tone_cnt <= '0;
            gate_cnt <= '0;
            tone     <= 1'b0;
            gate     <= 1'b1;
            buzzer   <= 1'b0;
        end else begin
            tone_cnt <= tone_cnt_n;
            gate_cnt <= gate_cnt_n;
            tone     <= tone_n;
            gate     <= gate_n;
            buzzer   <= tone_n & gate_n;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: expected outputs queued per clock edge.
// Honours LEADING_ZERO_BLANK_EN for the hour-tens digit.
module tb_display_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] time_data;
    logic        am_pm_div;
    logic        alerm_equal;
    logic [7:0]  seg;
    logic [5:0]  digit_sel;
    logic        buzzer;

    display_scan #(
        .SCAN_DIV(4),
        .BEEP_DIV(3),
        .GATE_DIV(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .time_data(time_data),
        .am_pm_div(am_pm_div),
        .alerm_equal(alerm_equal),
        .seg(seg),
        .digit_sel(digit_sel),
        .buzzer(buzzer)
    );

    always #5 clock = ~clock;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] H0 = 8'hFF;
`else
    localparam logic [7:0] H0 = 8'hC0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [5:0] sel;
        logic       buz;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc++;

    function automatic logic buz_exp(input int n);
        return n inside {104, 105, 106, 116, 128};
    endfunction

    task automatic push(input int c, input logic [7:0] s, input logic [5:0] d);
        exp_t e;
        e.cyc = c;
        e.seg = s;
        e.sel = d;
        e.buz = buz_exp(c);
        q.push_back(e);
    endtask

    task automatic push_digits(input int start, input logic [47:0] v, input int ndig);
        logic [5:0] s;
        for (int i = 0; i < ndig; i++) begin
            s = 6'b1 << i;
            s = ~s;
            for (int k = 0; k < 4; k++) push(start + 4 * i + k, v[47 - 8 * i -: 8], s);
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed cyc %0d (now %0d)", mon_e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            checks++;
            if ({seg, digit_sel, buzzer} !== {mon_e.seg, mon_e.sel, mon_e.buz}) begin
                errors++;
                $display("FAIL scan cyc %0d: seg %h sel %h buz %b, want seg %h sel %h buz %b",
                         cyc, seg, digit_sel, buzzer, mon_e.seg, mon_e.sel, mon_e.buz);
            end
        end
    end

    initial begin
        reset = 1'b0;
        time_data = '0;
        am_pm_div = 1'b0;
        alerm_equal = 1'b0;
        for (int c = 1; c <= 4; c++) push(c, 8'hFF, 6'h3F);

        wait_edge(4);
        reset = 1'b1;
        time_data = {6'd12, 6'd34, 6'd56};
        am_pm_div = 1'b1;
        push_digits(5, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h02}, 6);

        wait_edge(13);
        time_data = {6'd1, 6'd2, 6'd3};
        am_pm_div = 1'b0;
        push_digits(29, {H0, 8'hF9, 8'hC0, 8'hA4, 8'hC0, 8'hB0}, 6);

        wait_edge(40);
        time_data = {6'd12, 6'd63, 6'd5};
        am_pm_div = 1'b1;
        push_digits(53, {8'hF9, 8'hA4, 8'hBF, 8'hBF, 8'hC0, 8'h12}, 6);

        wait_edge(64);
        time_data = {6'd62, 6'd0, 6'd59};
        am_pm_div = 1'b0;
        push_digits(77, {8'hBF, 8'hBF, 8'hC0, 8'hC0, 8'h92, 8'h90}, 6);

        wait_edge(100);
        alerm_equal = 1'b1;
        push_digits(101, {8'hBF, 8'hBF, 8'hC0, 8'hC0, 8'h92, 8'h90}, 6);

        wait_edge(116);
        alerm_equal = 1'b0;

        wait_edge(124);
        alerm_equal = 1'b1;
        push_digits(125, {8'hBF, 8'hBF, 8'hC0, 8'hC0, 8'h92, 8'h90}, 1);

        wait_edge(128);
        reset = 1'b0;
        push(129, 8'hFF, 6'h3F);

        wait_edge(129);
        reset = 1'b1;
        alerm_equal = 1'b0;
        push_digits(130, {8'hBF, 8'hBF, 8'hC0, 8'hC0, 8'h92, 8'h90}, 2);

        wait_edge(140);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected entries, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
